// File: rtl/riscv_pkg.sv
// Shared RV32I branch definitions: funct3 encodings, BHT counter reset value
// and the conditional-branch compare used by the resolution path.
package riscv_pkg;

    // Operands are sign-extended to this width before comparing, so one
    // function serves any XLEN up to 64.
    localparam int OPND_W = 64;

    localparam logic [1:0] BR_CTR_RESET = 2'b01;

    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } branch_instr;

    function automatic logic branch_legal(input logic [2:0] funct3);
        return (funct3 != 3'b010) && (funct3 != 3'b011);
    endfunction

    // Sign extension preserves both signed and unsigned ordering, so the
    // unsigned compares stay correct on the widened operands.
    function automatic logic branch_taken(input logic [2:0]        funct3,
                                          input logic [OPND_W-1:0] rs1,
                                          input logic [OPND_W-1:0] rs2);
        logic result;
        result = 1'b0;
        case (funct3)
            BEQ:     result = (rs1 == rs2);
            BNE:     result = (rs1 != rs2);
            BLT:     result = ($signed(rs1) <  $signed(rs2));
            BGE:     result = ($signed(rs1) >= $signed(rs2));
            BLTU:    result = (rs1 <  rs2);
            BGEU:    result = (rs1 >= rs2);
            default: result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/branch_pred_unit_if.sv
// Fetch prediction, execute resolution and performance-counter signals of
// the branch prediction unit; master is the pipeline side, slave the unit.
interface branch_pred_unit_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic [XLEN-1:0]  pred_pc;
    logic             pred_taken;
    logic             res_valid;
    logic [XLEN-1:0]  res_pc;
    logic [2:0]       res_funct3;
    logic [XLEN-1:0]  res_rs1;
    logic [XLEN-1:0]  res_rs2;
    logic [XLEN-1:0]  res_imm;
    logic             res_pred_taken;
    logic             redirect_valid;
    logic [XLEN-1:0]  redirect_pc;
    logic             res_taken;
    logic             res_done;
    logic             illegal_br;
    logic             misalign;
    logic             perf_clr;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] mp_count;

    modport master (
        output pred_pc, res_valid, res_pc, res_funct3, res_rs1, res_rs2,
               res_imm, res_pred_taken, perf_clr,
        input  pred_taken, redirect_valid, redirect_pc, res_taken, res_done,
               illegal_br, misalign, br_count, mp_count
    );

    modport slave (
        input  pred_pc, res_valid, res_pc, res_funct3, res_rs1, res_rs2,
               res_imm, res_pred_taken, perf_clr,
        output pred_taken, redirect_valid, redirect_pc, res_taken, res_done,
               illegal_br, misalign, br_count, mp_count
    );
endinterface

// File: rtl/bht_2bit.sv
// Direct-mapped table of 2-bit saturating counters: asynchronous read port
// for fetch, single update port for resolved branches.
module bht_2bit
    import riscv_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_ctr,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    logic [1:0] ctr_all [ENTRIES];

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic [1:0] ctr_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ctr_reg <= BR_CTR_RESET;
                end else if (upd_en && (upd_idx == IDX_W'(gi))) begin
                    if (upd_taken) begin
                        if (ctr_reg != 2'b11) ctr_reg <= ctr_reg + 2'd1;
                    end else begin
                        if (ctr_reg != 2'b00) ctr_reg <= ctr_reg - 2'd1;
                    end
                end
            end

            assign ctr_all[gi] = ctr_reg;
        end
    endgenerate

    // Read sees the pre-update value when fetch and resolve collide.
    assign rd_ctr = ctr_all[rd_idx];

endmodule

// File: rtl/branch_pred_unit.sv
// Conditional-branch resolution with a 2-bit BHT predictor, registered
// redirect on mispredict and saturating branch/mispredict counters.
module branch_pred_unit
    import riscv_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    branch_pred_unit_if.slave bus
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [IDX_W-1:0]  pred_idx;
    logic [IDX_W-1:0]  res_idx;
    logic [1:0]        pred_ctr;
    logic              res_legal;
    logic              legal_valid;
    logic              act_taken;
    logic              mispredict;
    logic [OPND_W-1:0] rs1_ext;
    logic [OPND_W-1:0] rs2_ext;
    logic [XLEN-1:0]   take_tgt;
    logic [XLEN-1:0]   fall_pc;

    logic              redirect_valid_reg;
    logic [XLEN-1:0]   redirect_pc_reg;
    logic              res_taken_reg;
    logic              res_done_reg;
    logic              illegal_br_reg;
    logic              misalign_reg;
    logic [CNT_W-1:0]  br_count_reg;
    logic [CNT_W-1:0]  mp_count_reg;

    assign pred_idx = bus.pred_pc[IDX_W+1:2];
    assign res_idx  = bus.res_pc[IDX_W+1:2];

    bht_2bit #(
        .ENTRIES (BHT_ENTRIES),
        .IDX_W   (IDX_W)
    ) u_bht (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (pred_idx),
        .rd_ctr    (pred_ctr),
        .upd_en    (legal_valid),
        .upd_idx   (res_idx),
        .upd_taken (act_taken)
    );

    assign bus.pred_taken = pred_ctr[1];

    assign rs1_ext     = OPND_W'($signed(bus.res_rs1));
    assign rs2_ext     = OPND_W'($signed(bus.res_rs2));
    assign res_legal   = branch_legal(bus.res_funct3);
    assign legal_valid = bus.res_valid && res_legal;
    assign act_taken   = res_legal && branch_taken(bus.res_funct3, rs1_ext, rs2_ext);
    assign mispredict  = act_taken != bus.res_pred_taken;
    assign take_tgt    = bus.res_pc + bus.res_imm;
    assign fall_pc     = bus.res_pc + XLEN'(4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_valid_reg <= 1'b0;
            redirect_pc_reg    <= '0;
            res_taken_reg      <= 1'b0;
            res_done_reg       <= 1'b0;
            illegal_br_reg     <= 1'b0;
            misalign_reg       <= 1'b0;
            br_count_reg       <= '0;
            mp_count_reg       <= '0;
        end else begin
            res_done_reg       <= legal_valid;
            redirect_valid_reg <= legal_valid && mispredict;
            illegal_br_reg     <= bus.res_valid && !res_legal;
            misalign_reg       <= legal_valid && act_taken && (take_tgt[1:0] != 2'b00);

            // Outcome and next PC persist until the next legal resolution.
            if (legal_valid) begin
                res_taken_reg   <= act_taken;
                redirect_pc_reg <= act_taken ? take_tgt : fall_pc;
            end

            if (bus.perf_clr) begin
                br_count_reg <= '0;
                mp_count_reg <= '0;
            end else begin
                if (legal_valid && (br_count_reg != '1))
                    br_count_reg <= br_count_reg + CNT_W'(1);
                if (legal_valid && mispredict && (mp_count_reg != '1))
                    mp_count_reg <= mp_count_reg + CNT_W'(1);
            end
        end
    end

    assign bus.redirect_valid = redirect_valid_reg;
    assign bus.redirect_pc    = redirect_pc_reg;
    assign bus.res_taken      = res_taken_reg;
    assign bus.res_done       = res_done_reg;
    assign bus.illegal_br     = illegal_br_reg;
    assign bus.misalign       = misalign_reg;
    assign bus.br_count       = br_count_reg;
    assign bus.mp_count       = mp_count_reg;

endmodule

// File: tb/tb_branch_pred_unit.sv
// Scoreboard bench for branch_pred_unit: directed test-plan cases followed by
// random resolutions, checked against a behavioural BHT/counter model.
module tb_branch_pred_unit;

    localparam int XLEN  = 32;
    localparam int ENT   = 64;
    localparam int CNT_W = 32;
    localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    branch_pred_unit_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    branch_pred_unit #(
        .XLEN        (XLEN),
        .BHT_ENTRIES (ENT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit          pred;
        bit          done;
        bit          redir;
        logic [31:0] rpc;
        bit          taken;
        bit          ill;
        bit          mis;
        logic [31:0] brc;
        logic [31:0] mpc;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference state: counter values 0..3 per index, counters as plain integers.
    int              bht_m [ENT];
    longint unsigned brc_m, mpc_m;
    bit              taken_m;
    logic [31:0]     rpc_m;

    task automatic model_reset();
        for (int i = 0; i < ENT; i++) bht_m[i] = 1;
        brc_m   = 0;
        mpc_m   = 0;
        taken_m = 1'b0;
        rpc_m   = '0;
    endtask

    function automatic bit ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) <  $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            3'd6:    return a <  b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string tag, input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s/%s: got 0x%08h, expected 0x%08h", tag, name, act, req);
        end
    endtask

    // One cycle of stimulus; the expected outcome is queued for the monitor.
    task automatic step(input bit v, input logic [31:0] ppc, input logic [31:0] pc,
                        input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input bit pt, input bit clr,
                        input bit rst_mid, input string tag);
        exp_t        e;
        bit          legal, tk;
        logic [31:0] tgt;
        int          ri;
        @(negedge clk);
        rst                = 1'b0;
        bus.pred_pc        = ppc;
        bus.res_valid      = v;
        bus.res_pc         = pc;
        bus.res_funct3     = f3;
        bus.res_rs1        = a;
        bus.res_rs2        = b;
        bus.res_imm        = imm;
        bus.res_pred_taken = pt;
        bus.perf_clr       = clr;

        e.tag  = tag;
        e.pred = bht_m[(ppc / 4) % ENT] >= 2;
        legal  = v && (f3 != 3'd2) && (f3 != 3'd3);
        tk     = legal && ref_taken(f3, a, b);
        tgt    = pc + imm;
        e.done  = legal;
        e.redir = legal && (tk != pt);
        e.ill   = v && !legal;
        e.mis   = tk && ((tgt % 4) != 0);
        if (legal) begin
            taken_m = tk;
            rpc_m   = tk ? tgt : pc + 32'd4;
            ri      = (pc / 4) % ENT;
            if (tk && bht_m[ri] < 3) bht_m[ri]++;
            if (!tk && bht_m[ri] > 0) bht_m[ri]--;
            if (brc_m < CNT_MAX) brc_m++;
            if (tk != pt && mpc_m < CNT_MAX) mpc_m++;
        end
        if (clr) begin
            brc_m = 0;
            mpc_m = 0;
        end
        if (rst_mid) begin
            model_reset();
            e.done  = 1'b0;
            e.redir = 1'b0;
            e.ill   = 1'b0;
            e.mis   = 1'b0;
        end
        e.rpc   = rpc_m;
        e.taken = taken_m;
        e.brc   = brc_m[31:0];
        e.mpc   = mpc_m[31:0];
        sb.push_back(e);
        if (rst_mid) begin
            #3;
            rst = 1'b1;
        end
    endtask

    // Monitor: prediction sampled mid-cycle, registered outputs after the edge.
    initial begin
        bit   p;
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            p = bus.pred_taken;
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk(e.tag, "pred_taken",     32'(p),                  32'(e.pred));
                chk(e.tag, "res_done",       32'(bus.res_done),       32'(e.done));
                chk(e.tag, "redirect_valid", 32'(bus.redirect_valid), 32'(e.redir));
                chk(e.tag, "redirect_pc",    bus.redirect_pc,         e.rpc);
                chk(e.tag, "res_taken",      32'(bus.res_taken),      32'(e.taken));
                chk(e.tag, "illegal_br",     32'(bus.illegal_br),     32'(e.ill));
                chk(e.tag, "misalign",       32'(bus.misalign),       32'(e.mis));
                chk(e.tag, "br_count",       bus.br_count,            e.brc);
                chk(e.tag, "mp_count",       bus.mp_count,            e.mpc);
                $display("txn %-10s pred=%0d done=%0d redir=%0d pc=%08h taken=%0d ill=%0d mis=%0d br=%0d mp=%0d",
                         e.tag, p, bus.res_done, bus.redirect_valid, bus.redirect_pc,
                         bus.res_taken, bus.illegal_br, bus.misalign, bus.br_count, bus.mp_count);
            end
        end
    end

    initial begin
        logic [31:0] vals [6];
        logic [31:0] pc, ppc, a, b, imm;
        logic [12:0] i13;
        vals[0] = 32'h0;        vals[1] = 32'h1;        vals[2] = 32'h5;
        vals[3] = 32'h7FFFFFFF; vals[4] = 32'h80000000; vals[5] = 32'hFFFFFFFF;

        bus.pred_pc = '0; bus.res_valid = 1'b0; bus.res_pc = '0; bus.res_funct3 = '0;
        bus.res_rs1 = '0; bus.res_rs2 = '0; bus.res_imm = '0; bus.res_pred_taken = 1'b0;
        bus.perf_clr = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);

        // Reset state and first mispredicted BEQ.
        step(0, 32'h100, 32'h0,   3'd0, 32'd0, 32'd0, 32'd0,  0, 0, 0, "reset");
        step(1, 32'h100, 32'h100, 3'd0, 32'd5, 32'd5, 32'h20, 0, 0, 0, "beq");

        // Signed vs unsigned compares.
        step(1, 32'h0, 32'h200, 3'd4, 32'hFFFFFFFF, 32'd1, 32'h40, 0, 0, 0, "blt");
        step(1, 32'h0, 32'h200, 3'd6, 32'hFFFFFFFF, 32'd1, 32'h40, 1, 0, 0, "bltu");
        step(1, 32'h0, 32'h200, 3'd7, 32'hFFFFFFFF, 32'd1, 32'h40, 1, 0, 0, "bgeu");
        step(1, 32'h0, 32'h200, 3'd5, 32'hFFFFFFFF, 32'd1, 32'h40, 0, 0, 0, "bge");

        // Saturation up then down at one index, watching the prediction.
        for (int i = 0; i < 3; i++)
            step(1, 32'h300, 32'h300, 3'd0, 32'd7, 32'd7, 32'h10, 1, 0, 0, "sat_up");
        step(0, 32'h300, 32'h0, 3'd0, 32'd0, 32'd0, 32'd0, 0, 0, 0, "sat_chk");
        for (int i = 0; i < 3; i++)
            step(1, 32'h300, 32'h300, 3'd1, 32'd7, 32'd7, 32'h10, 0, 0, 0, "sat_dn");
        step(0, 32'h300, 32'h0, 3'd0, 32'd0, 32'd0, 32'd0, 0, 0, 0, "sat_chk");

        // Illegal funct3 leaves BHT and counters alone.
        step(1, 32'h300, 32'h300, 3'd2, 32'd7, 32'd7, 32'h10, 0, 0, 0, "illegal");
        step(0, 32'h300, 32'h0,   3'd0, 32'd0, 32'd0, 32'd0,  0, 0, 0, "ill_after");

        // Misaligned target and address wrap.
        step(1, 32'h0, 32'h400,      3'd1, 32'd1, 32'd2, 32'h6, 0, 0, 0, "misalign");
        step(1, 32'h0, 32'hFFFFFFFC, 3'd0, 32'd3, 32'd3, 32'h8, 0, 0, 0, "wrap");

        // Same-cycle read/update collision returns the old counter.
        step(1, 32'h500, 32'h500, 3'd0, 32'd1, 32'd1, 32'h8, 0, 0, 0, "collide");
        step(0, 32'h500, 32'h0,   3'd0, 32'd0, 32'd0, 32'd0, 0, 0, 0, "coll_after");

        // Clear wins over a coincident mispredict.
        step(1, 32'h0, 32'h600, 3'd0, 32'd1, 32'd1, 32'h8, 0, 1, 0, "perf_clr");

        // Reset mid-cycle discards the in-flight resolution.
        step(1, 32'h600, 32'h600, 3'd0, 32'd1, 32'd1, 32'h8, 0, 0, 0, "pre_rst");
        step(1, 32'h500, 32'h500, 3'd0, 32'd1, 32'd1, 32'h8, 0, 0, 1, "rst_mid");
        step(0, 32'h500, 32'h0,   3'd0, 32'd0, 32'd0, 32'd0, 0, 0, 0, "rst_after");

        // Random traffic over a small PC set to exercise aliasing.
        for (int n = 0; n < 400; n++) begin
            pc  = ($urandom_range(0, 2) == 0) ? 32'hFFFFFFFC : (32'h1000 | ($urandom_range(0, 95) << 2));
            ppc = ($urandom_range(0, 1) == 0) ? pc : (32'h1000 | ($urandom_range(0, 95) << 2));
            a   = ($urandom_range(0, 3) == 0) ? $urandom : vals[$urandom_range(0, 5)];
            b   = ($urandom_range(0, 3) == 0) ? a : vals[$urandom_range(0, 5)];
            i13 = 13'($urandom);
            if ($urandom_range(0, 3) != 0) i13[1:0] = 2'b00;
            i13[0] = 1'b0;
            imm = {{19{i13[12]}}, i13};
            step($urandom_range(0, 3) != 0, ppc, pc, 3'($urandom), a, b, imm,
                 1'($urandom), $urandom_range(0, 40) == 0, 0, "rand");
        end

        repeat (3) @(negedge clk);
        chk("end", "scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
